lpc_excitation: RTL and testbench
=================================

Name: lpc_excitation

Overview:
- Upstream excitation source for `synthfilt` in the LPC decoder path; supplies its `x` sample and `v` strobe.
- Per-frame parameters are voicing, pitch period and gain.
- Voiced frames produce a gain-scaled impulse train at the pitch period.
- Unvoiced frames produce gain-scaled 16-bit LFSR noise.
- Parameters are double-buffered and switch only on frame boundaries, so `synthfilt` coefficients and excitation stay frame-aligned.

Parameters:
- DW, 16, excitation sample width (signed).
- FRAME_LEN, 240, samples per LPC frame.
- LFSR_SEED, 16'hACE1, noise register reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; one excitation sample per `en` cycle.
- par_valid  in  1  frame parameters present.
- par_ready  out  1  shadow register empty; params accepted when `par_valid & par_ready`.
- voiced  in  1  1 = pulse train, 0 = noise.
- pitch  in  16  pitch period in samples (unsigned).
- gain  in  15  amplitude, unsigned Q0.15.
- x  out  DW  signed excitation sample (registered).
- v  out  1  `x` valid; to `synthfilt.v`.
- frame_start  out  1  pulses with the first `v` of each frame.
- underrun  out  1  one-cycle pulse: frame boundary reached with no pending params.

Behaviour:
- Reset values:
  - Outputs: x=0, v=0, frame_start=0, underrun=0, par_ready=1.
  - Internal: lfsr=LFSR_SEED, fcnt=0, pcnt=0, shadow empty, state=IDLE.
  - Reset mid-frame aborts immediately; no residual `v`.
- States:
  - IDLE: `en` ignored, v=0. Leave on first accepted params: params go straight to active regs, go to RUN; the next `en` is frame sample 0.
  - RUN: each `en` emits one sample.
- Latency: x/v/frame_start registered, valid the cycle after `en`; v = registered `en` in RUN.
- Frame counter:
  - `fcnt` 0..FRAME_LEN-1, increments per `en`, wraps to 0.
  - The `en` with fcnt==0 is the boundary: active params are loaded from shadow before the sample is computed, and frame_start=1.
- Boundary cases:
  - Shadow empty at boundary: keep current active params and pulse underrun.
  - `par_valid & par_ready` in the same cycle as a boundary `en`: incoming params bypass into active regs for that sample; shadow stays empty.
- Shadow register: `par_ready` drops after acceptance and rises again the cycle after the boundary consumes the shadow.
- Pitch handling:
  - Effective period P = max(pitch, 2).
  - `pcnt` advances per `en` in RUN regardless of voicing; wraps to 0 when pcnt >= P-1. A shrunken period wraps on the next sample.
  - `pcnt` is forced to 0 at a boundary only on an unvoiced→voiced transition; otherwise phase is continuous across frames.
- Voiced sample: x = (pcnt==0) ? {1'b0,gain} : 0.
- Unvoiced sample: x = ($signed(lfsr) * $signed({1'b0,gain})) >>> 15, truncated to DW. No overflow is possible because |result| ≤ 32767.
- LFSR:
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances on every `en` in RUN. The sample uses the pre-advance value.
- `en` low: all counters, LFSR and outputs hold, except v=0 and frame_start=0.

Optional Feature:
- Macro: EXC_JITTER_EN.
- Defined: at each voiced pulse, the next period is P+d, clamped ≥2, where d is decoded from lfsr[1:0]: 00→-1, 01/10→0, 11→+1. This adds natural pitch jitter.
- Undefined: exact period P; no jitter logic synthesized.

Decomposition:
- Shared package `lpc_pkg`: DW, FRAME_LEN, LFSR_SEED, LFSR tap constants, state enum {IDLE, RUN}.
- Sub-module `lpc_lfsr16`:
  - Ports: clk, rst, adv, seed, q.
  - Reusable by the noise path and by any later comfort-noise stage.

Test Plan:
- Reset, then par voiced=1 pitch=4 gain=8192, en every cycle for 240 samples → x = 8192,0,0,0 repeating, exactly 60 pulses; frame_start only on sample 0; v high 240 cycles, lagging `en` by 1.
- Unvoiced gain=32767 → first x = $signed(16'hACE1)*32767>>>15 = -21279; second sample uses 16'h59C3 (next LFSR state).
- pitch=0 and pitch=1 → pulse every 2nd sample. With EXC_JITTER_EN defined, the voiced pitch=4 stream has every inter-pulse gap in {3,4,5}.
- No new params at the 2nd boundary → underrun pulses once at sample 240; frame 2 repeats frame-1 params; par_ready stays 1.
- Params presented during frame 1 (par_ready→0) → applied exactly at sample 240; par_ready=1 at the cycle after. Same-cycle bypass case → new gain visible on sample 240 itself.
- Assert rst at sample 100 → next cycle x=0, v=0, state IDLE; the following frame restarts with fcnt=0 and LFSR=16'hACE1.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC excitation source.
// Contents: sample width, frame length, noise seed and tap mask, the
// excitation FSM state type, and the 16-bit LFSR step function.
package lpc_pkg;

  localparam int          DW        = 16;       // excitation sample width (signed)
  localparam int          FRAME_LEN = 240;      // samples per LPC frame
  localparam logic [15:0] LFSR_SEED = 16'hACE1; // nonzero noise seed
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One LFSR step: shift left, feedback enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lpc_lfsr16.sv
// 16-bit Fibonacci LFSR noise source.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, loads seed
//   adv  - advance one step this cycle
//   seed - reset value (must be nonzero)
//   q    - current register value
module lpc_lfsr16
  import lpc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/lpc_excitation.sv
// LPC excitation source: per sample strobe emits either a gain-scaled
// impulse train at the pitch period (voiced) or gain-scaled LFSR noise
// (unvoiced). Frame parameters are double-buffered and only take effect
// at frame boundaries so the excitation stays aligned with the filter
// coefficients of the same frame.
//
// Optional build macro: EXC_JITTER_EN adds +/-1 sample pitch jitter,
// chosen from the LFSR at each voiced pulse.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   en           - sample strobe, one output sample per en cycle in RUN
//   par_valid    - frame parameters offered
//   par_ready    - shadow register empty; accepted on par_valid & par_ready
//   voiced       - 1 = pulse train, 0 = noise
//   pitch[15:0]  - pitch period in samples
//   gain[14:0]   - amplitude, unsigned Q0.15
//   x[DW-1:0]    - signed excitation sample (registered)
//   v            - x valid (registered en while in RUN)
//   frame_start  - high with the first v of each frame
//   underrun     - one-cycle pulse: boundary reached with no pending params
//   fsm_state    - current FSM state (0 = IDLE, 1 = RUN) for observation
//
// Handshake: parameters transfer on a cycle where par_valid and par_ready
// are both high; par_valid may be held, the source must keep the fields
// stable until the transfer cycle, and par_ready does not depend on
// par_valid.
module lpc_excitation
  import lpc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          par_valid,
  output logic          par_ready,
  input  logic          voiced,
  input  logic [15:0]   pitch,
  input  logic [14:0]   gain,
  output logic [DW-1:0] x,
  output logic          v,
  output logic          frame_start,
  output logic          underrun,
  output logic          fsm_state
);

  state_t      state;

  // Active frame parameters
  logic        act_voiced;
  logic [15:0] act_pitch;
  logic [14:0] act_gain;

  // Shadow (next-frame) parameters
  logic        sh_valid;
  logic        sh_voiced;
  logic [15:0] sh_pitch;
  logic [14:0] sh_gain;

  logic [15:0] fcnt;
  logic [15:0] pcnt;
  // Set between leaving IDLE and the first sample: that boundary already
  // has fresh parameters, so it must not report an underrun.
  logic        first;

  logic [15:0] lfsr_q;

  logic        accept;
  logic        run_en;
  logic        boundary;
  logic        bypass;
  logic        use_shadow;
  logic        underrun_now;
  logic        sel_voiced;
  logic [15:0] sel_pitch;
  logic [14:0] sel_gain;
  logic [15:0] pcnt_cur;
  logic        pulse;
  logic [16:0] per;
  logic [16:0] per_eff;
  logic        wrap;
  logic [15:0] pcnt_next;
  logic [15:0] fcnt_next;
  logic signed [31:0] noise_a;
  logic signed [31:0] noise_g;
  logic signed [31:0] noise_p;
  logic signed [31:0] noise_s;
  logic [DW-1:0] x_next;

`ifdef EXC_JITTER_EN
  logic [1:0]  jit_code;
  logic [1:0]  code_now;
`endif

  assign par_ready = ~sh_valid;
  assign fsm_state = state;

  lpc_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (run_en),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  always_comb begin
    accept       = par_valid & par_ready;
    run_en       = (state == RUN) & en;
    boundary     = run_en & (fcnt == 16'd0);
    bypass       = boundary & accept;
    use_shadow   = boundary & ~accept & sh_valid;
    underrun_now = boundary & ~accept & ~sh_valid & ~first;

    // Parameters used for this sample (boundary loads happen first).
    sel_voiced = act_voiced;
    sel_pitch  = act_pitch;
    sel_gain   = act_gain;
    if (bypass) begin
      sel_voiced = voiced;
      sel_pitch  = pitch;
      sel_gain   = gain;
    end else if (use_shadow) begin
      sel_voiced = sh_voiced;
      sel_pitch  = sh_pitch;
      sel_gain   = sh_gain;
    end

    // Pulse phase restarts only when a frame turns from noise to voiced.
    pcnt_cur = pcnt;
    if (boundary && !act_voiced && sel_voiced) begin
      pcnt_cur = 16'd0;
    end
    pulse = sel_voiced & (pcnt_cur == 16'd0);

    per = (sel_pitch < 16'd2) ? 17'd2 : {1'b0, sel_pitch};
`ifdef EXC_JITTER_EN
    // A new offset is drawn at each pulse and held for the whole period.
    code_now = pulse ? lfsr_q[1:0] : jit_code;
    case (code_now)
      2'b00:   per_eff = (per == 17'd2) ? 17'd2 : per - 17'd1;
      2'b11:   per_eff = per + 17'd1;
      default: per_eff = per;
    endcase
`else
    per_eff = per;
`endif
    wrap      = ({1'b0, pcnt_cur} >= (per_eff - 17'd1));
    pcnt_next = wrap ? 16'd0 : pcnt_cur + 16'd1;
    fcnt_next = (fcnt == 16'(FRAME_LEN - 1)) ? 16'd0 : fcnt + 16'd1;

    // |lfsr * gain| >> 15 stays within 16 bits, so truncation is exact.
    noise_a = {{16{lfsr_q[15]}}, lfsr_q};
    noise_g = {17'd0, sel_gain};
    noise_p = noise_a * noise_g;
    noise_s = noise_p >>> 15;

    if (sel_voiced) begin
      x_next = pulse ? DW'({1'b0, sel_gain}) : '0;
    end else begin
      x_next = noise_s[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      act_voiced  <= 1'b0;
      act_pitch   <= 16'd0;
      act_gain    <= 15'd0;
      sh_valid    <= 1'b0;
      sh_voiced   <= 1'b0;
      sh_pitch    <= 16'd0;
      sh_gain     <= 15'd0;
      fcnt        <= 16'd0;
      pcnt        <= 16'd0;
      first       <= 1'b0;
      x           <= '0;
      v           <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
`ifdef EXC_JITTER_EN
      jit_code    <= 2'b01;
`endif
    end else begin
      v           <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      case (state)
        IDLE: begin
          // First parameters go straight to the active set.
          if (accept) begin
            act_voiced <= voiced;
            act_pitch  <= pitch;
            act_gain   <= gain;
            fcnt       <= 16'd0;
            pcnt       <= 16'd0;
            first      <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (accept && !boundary) begin
            sh_valid  <= 1'b1;
            sh_voiced <= voiced;
            sh_pitch  <= pitch;
            sh_gain   <= gain;
          end
          if (run_en) begin
            act_voiced  <= sel_voiced;
            act_pitch   <= sel_pitch;
            act_gain    <= sel_gain;
            if (use_shadow) begin
              sh_valid <= 1'b0;
            end
            x           <= x_next;
            v           <= 1'b1;
            frame_start <= boundary;
            underrun    <= underrun_now;
            fcnt        <= fcnt_next;
            pcnt        <= pcnt_next;
            first       <= 1'b0;
`ifdef EXC_JITTER_EN
            if (pulse) begin
              jit_code <= lfsr_q[1:0];
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_excitation.sv
// Bench for lpc_excitation (default build, EXC_JITTER_EN undefined).
// Short per-frame vectors from a table, then hand-written sequences for
// full frames, underrun, shadow loading, same-cycle bypass and reset.
module tb_lpc_excitation;

  logic        clk;
  logic        rst;
  logic        en;
  logic        par_valid;
  logic        par_ready;
  logic        voiced;
  logic [15:0] pitch;
  logic [14:0] gain;
  logic [15:0] x;
  logic        v;
  logic        frame_start;
  logic        underrun;
  logic        fsm_state;

  int checks;
  int failures;

  // Scoreboard entries are {frame_start, x}.
  logic [16:0] exp_q[$];

  int v_cnt;
  int pulse_cnt;
  int fs_cnt;
  int ur_cnt;

  lpc_excitation dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .par_valid   (par_valid),
    .par_ready   (par_ready),
    .voiced      (voiced),
    .pitch       (pitch),
    .gain        (gain),
    .x           (x),
    .v           (v),
    .frame_start (frame_start),
    .underrun    (underrun),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; par_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic send_params(input logic vo, input logic [15:0] p, input logic [14:0] g);
    en = 1'b0;
    par_valid = 1'b1; voiced = vo; pitch = p; gain = g;
    cyc();
    par_valid = 1'b0;
  endtask

  // One en cycle; en is left high so consecutive calls stream samples.
  task automatic sample(input logic fs, input logic [15:0] ex);
    en = 1'b1;
    exp_q.push_back({fs, ex});
    cyc();
  endtask

  task automatic idle();
    en = 1'b0;
    cyc();
  endtask

  // Expected value of an exact-period impulse train, n samples in.
  function automatic logic [15:0] pulse_at(input int n, input int per, input logic [14:0] g);
    return ((n % per) == 0) ? {1'b0, g} : 16'd0;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (v) begin
      v_cnt++;
      if (x != 16'd0) pulse_cnt++;
      if (frame_start) fs_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sample: got unexpected v with x=%0d, expected no sample", $signed(x));
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({frame_start, x} !== e) begin
          failures++;
          $display("FAIL sample: got fs=%0b x=%0d, expected fs=%0b x=%0d",
                   frame_start, $signed(x), e[16], $signed(e[15:0]));
        end
      end
    end
    if (underrun) ur_cnt++;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        vo;
    logic [15:0] p;
    logic [14:0] g;
    logic [15:0] exp[4];
  } vec_t;

  vec_t tbl[6];

  initial begin
    int v0, p0, f0, u0;
    checks = 0; failures = 0;
    v_cnt = 0; pulse_cnt = 0; fs_cnt = 0; ur_cnt = 0;
    rst = 1'b1; en = 1'b0; par_valid = 1'b0; voiced = 1'b0; pitch = 16'd0; gain = 15'd0;

    tbl[0].vo = 1'b1; tbl[0].p = 16'd4; tbl[0].g = 15'd8192;
    tbl[0].exp[0] = 16'd8192; tbl[0].exp[1] = 16'd0; tbl[0].exp[2] = 16'd0; tbl[0].exp[3] = 16'd0;
    tbl[1].vo = 1'b1; tbl[1].p = 16'd0; tbl[1].g = 15'd1000;
    tbl[1].exp[0] = 16'd1000; tbl[1].exp[1] = 16'd0; tbl[1].exp[2] = 16'd1000; tbl[1].exp[3] = 16'd0;
    tbl[2].vo = 1'b1; tbl[2].p = 16'd1; tbl[2].g = 15'd1000;
    tbl[2].exp[0] = 16'd1000; tbl[2].exp[1] = 16'd0; tbl[2].exp[2] = 16'd1000; tbl[2].exp[3] = 16'd0;
    tbl[3].vo = 1'b1; tbl[3].p = 16'd3; tbl[3].g = 15'd5;
    tbl[3].exp[0] = 16'd5; tbl[3].exp[1] = 16'd0; tbl[3].exp[2] = 16'd0; tbl[3].exp[3] = 16'd5;
    // Noise from seed: LFSR ACE1, 59C3, B387, 670F.
    tbl[4].vo = 1'b0; tbl[4].p = 16'd4; tbl[4].g = 15'd32767;
    tbl[4].exp[0] = -16'sd21279; tbl[4].exp[1] = 16'sd22978;
    tbl[4].exp[2] = -16'sd19577; tbl[4].exp[3] = 16'sd26382;
    tbl[5].vo = 1'b0; tbl[5].p = 16'd4; tbl[5].g = 15'd16384;
    tbl[5].exp[0] = -16'sd10640; tbl[5].exp[1] = 16'sd11489;
    tbl[5].exp[2] = -16'sd9789;  tbl[5].exp[3] = 16'sd13191;

    // ---- reset state ----
    do_reset();
    check("reset_x", {16'd0, x}, 32'd0);
    check("reset_v", {31'd0, v}, 32'd0);
    check("reset_frame_start", {31'd0, frame_start}, 32'd0);
    check("reset_underrun", {31'd0, underrun}, 32'd0);
    check("reset_par_ready", {31'd0, par_ready}, 32'd1);
    check("reset_state_idle", {31'd0, fsm_state}, 32'd0);
    // en in IDLE is ignored
    idle(); en = 1'b1; cyc(); cyc(); en = 1'b0; cyc();
    check("idle_ignores_en", {31'd0, v}, 32'd0);

    // ---- table vectors ----
    for (int i = 0; i < 6; i++) begin
      do_reset();
      send_params(tbl[i].vo, tbl[i].p, tbl[i].g);
      check("state_run_after_params", {31'd0, fsm_state}, 32'd1);
      for (int k = 0; k < 4; k++) sample(k == 0, tbl[i].exp[k]);
      idle();
    end

    // ---- full voiced frame, then underrun at sample 240 ----
    do_reset();
    send_params(1'b1, 16'd4, 15'd8192);
    v0 = v_cnt; p0 = pulse_cnt; f0 = fs_cnt; u0 = ur_cnt;
    for (int n = 0; n < 240; n++) sample(n == 0, pulse_at(n, 4, 15'd8192));
    idle();
    check("frame1_v_count", v_cnt - v0, 32'd240);
    check("frame1_pulses", pulse_cnt - p0, 32'd60);
    check("frame1_frame_starts", fs_cnt - f0, 32'd1);
    check("frame1_no_underrun", ur_cnt - u0, 32'd0);
    sample(1'b1, 16'd8192);
    check("underrun_at_240", {31'd0, underrun}, 32'd1);
    check("par_ready_after_underrun", {31'd0, par_ready}, 32'd1);
    for (int n = 241; n < 248; n++) sample(1'b0, pulse_at(n, 4, 15'd8192));
    check("underrun_one_cycle", {31'd0, underrun}, 32'd0);
    idle();
    check("underrun_total", ur_cnt - u0, 32'd1);

    // ---- shadow load: params during frame 1 applied at sample 240 ----
    do_reset();
    send_params(1'b1, 16'd4, 15'd8192);
    for (int n = 0; n < 50; n++) sample(n == 0, pulse_at(n, 4, 15'd8192));
    send_params(1'b1, 16'd4, 15'd100);
    check("par_ready_drops", {31'd0, par_ready}, 32'd0);
    for (int n = 50; n < 240; n++) sample(1'b0, pulse_at(n, 4, 15'd8192));
    check("par_ready_low_before_boundary", {31'd0, par_ready}, 32'd0);
    u0 = ur_cnt;
    sample(1'b1, 16'd100);
    check("par_ready_after_boundary", {31'd0, par_ready}, 32'd1);
    for (int n = 241; n < 245; n++) sample(1'b0, pulse_at(n, 4, 15'd100));
    idle();
    check("shadow_no_underrun", ur_cnt - u0, 32'd0);

    // ---- same-cycle bypass at boundary ----
    do_reset();
    send_params(1'b1, 16'd4, 15'd8192);
    for (int n = 0; n < 240; n++) sample(n == 0, pulse_at(n, 4, 15'd8192));
    u0 = ur_cnt;
    par_valid = 1'b1; voiced = 1'b1; pitch = 16'd4; gain = 15'd200;
    sample(1'b1, 16'd200);
    par_valid = 1'b0;
    check("bypass_par_ready", {31'd0, par_ready}, 32'd1);
    check("bypass_no_underrun", {31'd0, underrun}, 32'd0);
    for (int n = 241; n < 246; n++) sample(1'b0, pulse_at(n, 4, 15'd200));
    idle();
    check("bypass_underrun_total", ur_cnt - u0, 32'd0);

    // ---- reset mid-frame ----
    do_reset();
    send_params(1'b1, 16'd4, 15'd8192);
    for (int n = 0; n < 100; n++) sample(n == 0, pulse_at(n, 4, 15'd8192));
    rst = 1'b1; en = 1'b1;
    cyc();
    check("midreset_x", {16'd0, x}, 32'd0);
    check("midreset_v", {31'd0, v}, 32'd0);
    check("midreset_state", {31'd0, fsm_state}, 32'd0);
    rst = 1'b0; en = 1'b0;
    cyc();
    check("midreset_no_residual_v", {31'd0, v}, 32'd0);
    send_params(1'b0, 16'd0, 15'd32767);
    sample(1'b1, -16'sd21279);
    sample(1'b0, 16'sd22978);
    idle();

    idle();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
